rtype_imem_responder: RTL and testbench

RTYPE_IMEM_RESPONDER -- requirements
Module: rtype_imem_responder

---
 rtl/rtype_imem_responder_pkg.sv | 25 ++
 rtl/rtype_imem_responder_lfsr.sv | 20 ++
 rtl/rtype_imem_responder.sv | 106 ++++++++++
 tb/tb_rtype_imem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtype_imem_responder_pkg.sv
// Shared types and constants for the R-type instruction-memory responder.
// Holds the FSM encoding, RV32 opcode/NOP constants and the LFSR tap mask.
package rtype_imem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [6:0]  RTYPE_OPCODE = 7'b0110011;
  localparam logic [31:0] NOP_INSN     = 32'h00000013;
  localparam logic [31:0] LFSR_MASK    = 32'h80200003;
  localparam logic [6:0]  FUNCT7_ALT   = 7'h20;

  // SUB/SRA encodings only exist for funct3 of ADD (0) and SRL (5).
  function automatic logic [31:0] rtype_word(input logic [31:0] l, input logic alt_en);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = l[7:5];
    f7 = (alt_en && l[18] && (f3 == 3'd0 || f3 == 3'd5)) ? FUNCT7_ALT : 7'h00;
    return {f7, l[17:13], l[12:8], f3, l[4:0], RTYPE_OPCODE};
  endfunction

endpackage

// File: rtl/rtype_imem_responder_lfsr.sv
// 32-bit Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module sodor_lfsr32
  import rtype_imem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= (seed == '0) ? 32'h00000001 : seed;
    end else if (step) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_MASK : '0);
    end
  end

endmodule

// File: rtl/rtype_imem_responder.sv
// Instruction-memory stand-in: answers each fetch with a pseudo-random RV32 R-type
// word after a fixed latency, preceded by a configurable run of NOPs after reset.
module rtype_imem_responder
  import rtype_imem_responder_pkg::*;
#(
  parameter logic [31:0] SEED      = 32'h00000190,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned NOP_COUNT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        resp_ready,
  input  logic        alt_en,
  output logic [15:0] issued
);

  localparam logic [2:0] LAT_LOAD = 3'(LATENCY - 1);
  localparam logic [3:0] NOP_INIT = 4'(NOP_COUNT);

  state_t      state, state_nxt;
  logic [2:0]  lat_cnt;
  logic [3:0]  nop_cnt;
  logic        armed;
  logic [31:0] lfsr_state;
  logic [31:0] resp_data_q;
  logic        resp_nop_q;
  logic [15:0] issued_q;
  logic        accept;
  logic        complete;
  logic        enter_resp;
  logic        lfsr_step;
  logic        unused_addr;

  always_comb unused_addr = ^req_addr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (lat_cnt <= 3'd1) state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; armed holds req_ready low until the first clock after reset release
  always_comb begin
    req_ready  = armed && (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    resp_data  = resp_data_q;
    issued     = issued_q;
    accept     = req_valid && req_ready;
    complete   = (state == ST_RESP) && resp_ready;
    enter_resp = (state != ST_RESP) && (state_nxt == ST_RESP);
    lfsr_step  = complete && !resp_nop_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed       <= 1'b0;
      lat_cnt     <= '0;
      nop_cnt     <= NOP_INIT;
      resp_data_q <= '0;
      resp_nop_q  <= 1'b0;
      issued_q    <= '0;
    end else begin
      armed <= 1'b1;

      if (accept)                lat_cnt <= LAT_LOAD;
      else if (state == ST_WAIT) lat_cnt <= lat_cnt - 3'd1;

      // Word and alt_en are captured once on entry so the response stays stable
      if (enter_resp) begin
        resp_data_q <= (nop_cnt != '0) ? NOP_INSN : rtype_word(lfsr_state, alt_en);
        resp_nop_q  <= (nop_cnt != '0);
      end else if (complete) begin
        resp_data_q <= '0;
      end

      if (complete && resp_nop_q) nop_cnt <= nop_cnt - 4'd1;

      if (lfsr_step && (issued_q != 16'hFFFF)) issued_q <= issued_q + 16'd1;
    end
  end

  sodor_lfsr32 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (SEED),
    .step    (lfsr_step),
    .state   (lfsr_state)
  );

endmodule

// File: tb/tb_rtype_imem_responder.sv
// Self-checking bench: default-parameter instance driven from a vector table with a
// scoreboard model, plus latency-3 and alt-encoding instances for corner sequences.
module tb_rtype_imem_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        req_valid = 1'b0, resp_ready = 1'b0, alt_en = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_data;
  logic [15:0] issued;
  // LATENCY=3 instance
  logic        req_valid_3 = 1'b0, resp_ready_3 = 1'b0, alt_en_3 = 1'b0;
  logic [31:0] req_addr_3 = '0;
  logic        req_ready_3, resp_valid_3;
  logic [31:0] resp_data_3;
  logic [15:0] issued_3;
  // alt-encoding instance
  logic        req_valid_a = 1'b0, resp_ready_a = 1'b0, alt_en_a = 1'b0;
  logic [31:0] req_addr_a = '0;
  logic        req_ready_a, resp_valid_a;
  logic [31:0] resp_data_a;
  logic [15:0] issued_a;

  rtype_imem_responder u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .alt_en(alt_en), .issued(issued)
  );

  rtype_imem_responder #(.SEED(32'h00002A45), .LATENCY(3), .NOP_COUNT(0)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_3), .req_addr(req_addr_3),
    .req_ready(req_ready_3), .resp_valid(resp_valid_3), .resp_data(resp_data_3),
    .resp_ready(resp_ready_3), .alt_en(alt_en_3), .issued(issued_3)
  );

  rtype_imem_responder #(.SEED(32'h00040000), .LATENCY(2), .NOP_COUNT(0)) u_alt (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_a), .req_addr(req_addr_a),
    .req_ready(req_ready_a), .resp_valid(resp_valid_a), .resp_data(resp_data_a),
    .resp_ready(resp_ready_a), .alt_en(alt_en_a), .issued(issued_a)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] word; bit nop; } sb_t;
  sb_t sbq[$];

  typedef struct { bit alt; int unsigned stall; bit exp_nop; logic [15:0] exp_issued; } vec_t;
  vec_t tbl[8];

  logic [31:0] m_lfsr;
  int          m_nop;
  logic [15:0] m_issued;
  int          n_done;
  bit          last_nop;

  function automatic logic [31:0] ref_next(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] l, input bit alt);
    logic [31:0] w, f3;
    f3 = (l >> 5) & 32'h7;
    w = 32'h33 | ((l & 32'h1F) << 7) | (f3 << 12) | (((l >> 8) & 32'h1F) << 15)
      | (((l >> 13) & 32'h1F) << 20);
    if (alt && l[18] && (f3 == 32'd0 || f3 == 32'd5)) w = w | 32'h40000000;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One cycle on the default instance with scoreboard push on accept, pop on completion
  task automatic tick();
    sb_t e;
    bit  did;
    did = 1'b0;
    if (req_valid && req_ready) begin
      e.nop  = (m_nop != 0);
      e.word = e.nop ? 32'h00000013 : ref_word(m_lfsr, alt_en);
      sbq.push_back(e);
    end
    if (resp_valid && resp_ready) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got response %h expected none", resp_data);
      end else begin
        e = sbq.pop_front();
        chk("resp_word", resp_data, e.word);
        if (n_done < 2) chk("first_nop", resp_data, 32'h00000013);
        last_nop = e.nop;
        if (e.nop) m_nop--;
        else begin
          m_lfsr = ref_next(m_lfsr);
          if (m_issued != 16'hFFFF) m_issued++;
        end
        n_done++;
        did = 1'b1;
      end
    end
    step();
    if (did) chk("issued", {16'h0, issued}, {16'h0, m_issued});
    if (!resp_valid) chk("idle_data_zero", resp_data, 32'h0);
  endtask

  task automatic reset_all();
    reset_n = 1'b0;
    #1;
    chk("rst_ready",    {31'h0, req_ready},    32'h0);
    chk("rst_valid",    {31'h0, resp_valid},   32'h0);
    chk("rst_data",     resp_data,             32'h0);
    chk("rst_issued",   {16'h0, issued},       32'h0);
    chk("rst_valid_3",  {31'h0, resp_valid_3}, 32'h0);
    chk("rst_data_3",   resp_data_3,           32'h0);
    chk("rst_valid_a",  {31'h0, resp_valid_a}, 32'h0);
    m_lfsr = 32'h00000190; m_nop = 2; m_issued = '0; n_done = 0;
    sbq.delete();
    step(); step();
    reset_n = 1'b1;
    #1;
    chk("rel_ready_lo", {31'h0, req_ready}, 32'h0);
    step();
    chk("rel_ready_hi",   {31'h0, req_ready},   32'h1);
    chk("rel_ready_hi_3", {31'h0, req_ready_3}, 32'h1);
  endtask

  task automatic do_txn(input bit alt, input int unsigned stall);
    int unsigned w;
    logic [31:0] held;
    alt_en = alt; req_addr = $urandom; req_valid = 1'b1; resp_ready = 1'b0;
    w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    if (!req_ready) begin total++; bad++; $display("FAIL req_timeout: ready=%b required 1", req_ready); end
    tick();
    w = 0;
    while (!resp_valid && w < 20) begin tick(); w++; end
    chk("resp_valid", {31'h0, resp_valid}, 32'h1);
    held = resp_data;
    alt_en = ~alt;
    for (int i = 0; i < int'(stall); i++) begin
      chk("stall_ready", {31'h0, req_ready}, 32'h0);
      chk("stall_data",  resp_data, held);
      tick();
    end
    chk("stall_valid", {31'h0, resp_valid}, 32'h1);
    chk("stall_end_data", resp_data, held);
    resp_ready = 1'b1; req_valid = 1'b0;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] l2;
    int unsigned w;

    tbl[0] = '{alt: 1'b0, stall: 0, exp_nop: 1'b1, exp_issued: 16'd0};
    tbl[1] = '{alt: 1'b1, stall: 2, exp_nop: 1'b1, exp_issued: 16'd0};
    tbl[2] = '{alt: 1'b0, stall: 0, exp_nop: 1'b0, exp_issued: 16'd1};
    tbl[3] = '{alt: 1'b1, stall: 5, exp_nop: 1'b0, exp_issued: 16'd2};
    tbl[4] = '{alt: 1'b1, stall: 0, exp_nop: 1'b0, exp_issued: 16'd3};
    tbl[5] = '{alt: 1'b0, stall: 1, exp_nop: 1'b0, exp_issued: 16'd4};
    tbl[6] = '{alt: 1'b1, stall: 3, exp_nop: 1'b0, exp_issued: 16'd5};
    tbl[7] = '{alt: 1'b1, stall: 0, exp_nop: 1'b0, exp_issued: 16'd6};

    step();
    reset_all();
    foreach (tbl[i]) begin
      do_txn(tbl[i].alt, tbl[i].stall);
      chk("tbl_nop",    {31'h0, last_nop}, {31'h0, tbl[i].exp_nop});
      chk("tbl_issued", {16'h0, issued},   {16'h0, tbl[i].exp_issued});
    end
    chk("sb_drained", sbq.size(), 32'd0);

    // Streaming after reset: two NOPs, then five R-type words
    reset_all();
    req_valid = 1'b1; resp_ready = 1'b1; alt_en = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("stream_count",  n_done,           32'd7);
    chk("stream_issued", {16'h0, issued},  32'd5);

    // LATENCY=3 timing and the reference slt word
    reset_all();
    req_valid_3 = 1'b1;
    chk("l3_ready_N", {31'h0, req_ready_3}, 32'h1);
    step(); req_valid_3 = 1'b0;
    chk("l3_ready_N1", {31'h0, req_ready_3},  32'h0);
    chk("l3_valid_N1", {31'h0, resp_valid_3}, 32'h0);
    step();
    chk("l3_ready_N2", {31'h0, req_ready_3},  32'h0);
    chk("l3_valid_N2", {31'h0, resp_valid_3}, 32'h0);
    step();
    chk("l3_ready_N3", {31'h0, req_ready_3},  32'h0);
    chk("l3_valid_N3", {31'h0, resp_valid_3}, 32'h1);
    chk("l3_word",     resp_data_3,           32'h001522B3);
    resp_ready_3 = 1'b1; step(); resp_ready_3 = 1'b0;
    chk("l3_issued",   {16'h0, issued_3},     32'd1);
    chk("l3_data_clr", resp_data_3,           32'h0);

    // Reset while in WAIT drops the response
    req_valid_3 = 1'b1; step(); req_valid_3 = 1'b0;
    reset_all();
    chk("l3_wait_rst_issued", {16'h0, issued_3}, 32'd0);
    req_valid_3 = 1'b1; step(); req_valid_3 = 1'b0;
    step(); step();
    chk("l3_after_wait_rst", resp_data_3, 32'h001522B3);

    // Reset while in RESP drops it too
    reset_all();
    req_valid_3 = 1'b1; step(); req_valid_3 = 1'b0;
    step(); step();
    resp_ready_3 = 1'b1; step(); resp_ready_3 = 1'b0;
    l2 = ref_next(32'h00002A45);
    req_valid_3 = 1'b1; step(); req_valid_3 = 1'b0;
    step(); step();
    chk("l3_second_word", resp_data_3, ref_word(l2, 1'b0));
    reset_all();
    req_valid_3 = 1'b1; step(); req_valid_3 = 1'b0;
    step(); step();
    chk("l3_resp_rst_word", resp_data_3, 32'h001522B3);
    resp_ready_3 = 1'b1; step(); resp_ready_3 = 1'b0;
    chk("l3_resp_rst_issued", {16'h0, issued_3}, 32'd1);

    // alt_en selects funct7=0x20 and is captured on entry to RESP
    reset_all();
    alt_en_a = 1'b1; req_valid_a = 1'b1; step(); req_valid_a = 1'b0;
    w = 0;
    while (!resp_valid_a && w < 10) begin step(); w++; end
    chk("alt_word",   resp_data_a, 32'h40000033);
    alt_en_a = 1'b0; step();
    chk("alt_held",   resp_data_a, 32'h40000033);
    resp_ready_a = 1'b1; step(); resp_ready_a = 1'b0;
    chk("alt_issued", {16'h0, issued_a}, 32'd1);
    reset_all();
    alt_en_a = 1'b0; req_valid_a = 1'b1; step(); req_valid_a = 1'b0;
    w = 0;
    while (!resp_valid_a && w < 10) begin step(); w++; end
    chk("noalt_word", resp_data_a, 32'h00000033);
    resp_ready_a = 1'b1; step(); resp_ready_a = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
